// File: rtl/cofre_controlador_if.sv
// Vault-door controller signal bundle: debounced buttons/sensors in, lock and indicators out.
// master drives the sensors/buttons, slave is the controller.
interface cofre_controlador_if;
  logic       pedido;
  logic       chave;
  logic       relogio;
  logic       porta_aberta;
  logic       trava;
  logic       alarme;
  logic       aviso_porta;
  logic       bloqueado;
  logic [2:0] estado;

  modport master (
    output pedido, chave, relogio, porta_aberta,
    input  trava, alarme, aviso_porta, bloqueado, estado
  );

  modport slave (
    input  pedido, chave, relogio, porta_aberta,
    output trava, alarme, aviso_porta, bloqueado, estado
  );
endinterface

// File: rtl/cofre_controlador.sv
// Vault-door controller: lock/unlock FSM with unlock and door-open timers, failed-attempt lockout, latched alarm.
// All outputs are registered and reflect inputs one clk_2 edge later; no backpressure, inputs are levels.
module cofre_controlador #(
  parameter int unsigned CW           = 8,
  parameter int unsigned T_DESTRAVA   = 5,
  parameter int unsigned T_ABERTA     = 10,
  parameter int unsigned T_BLOQUEIO   = 8,
  parameter int unsigned N_TENTATIVAS = 3
) (
  input logic               clk_2,
  input logic               rst_n,
  cofre_controlador_if.slave bus
);

  localparam int unsigned TW = $clog2(N_TENTATIVAS + 1);

  localparam logic [CW-1:0] CNT_MAX      = '1;
  localparam logic [CW-1:0] LIM_DESTRAVA = CW'(T_DESTRAVA - 1);
  localparam logic [CW-1:0] LIM_BLOQUEIO = CW'(T_BLOQUEIO - 1);
  localparam logic [CW-1:0] LIM_ABERTA   = CW'(T_ABERTA);
  localparam logic [TW-1:0] N_TENT       = TW'(N_TENTATIVAS);

  typedef enum logic [2:0] {
    FECHADO    = 3'd0,
    DESTRAVADO = 3'd1,
    ABERTO     = 3'd2,
    BLOQUEADO  = 3'd3,
    ALARME     = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tent_q, tent_d;
  logic [TW-1:0] tent_inc;
  logic          pedido_q;
  logic          trava_q;
  logic          alarme_q;
  logic          aviso_q;
  logic          bloq_q;
  logic          ev;

  // A held button produces a single request event.
  assign ev       = bus.pedido & ~pedido_q;
  assign tent_inc = tent_q + TW'(1);

  always_comb begin
    state_d = state_q;
    tent_d  = tent_q;
    case (state_q)
      FECHADO: begin
        if (bus.porta_aberta) begin
          state_d = ALARME;
        end else if (ev && bus.relogio) begin
          if (bus.chave) begin
            state_d = DESTRAVADO;
            tent_d  = '0;
          end else begin
            tent_d = tent_inc;
            if (tent_inc == N_TENT) begin
              state_d = BLOQUEADO;
            end
          end
        end
      end
      DESTRAVADO: begin
        // Door opening wins over both the time-lock and the window timeout.
        if (bus.porta_aberta) begin
          state_d = ABERTO;
        end else if (!bus.relogio || cnt_q == LIM_DESTRAVA) begin
          state_d = FECHADO;
        end
      end
      ABERTO: begin
        if (!bus.porta_aberta) begin
          state_d = FECHADO;
        end
      end
      BLOQUEADO: begin
        if (bus.porta_aberta) begin
          state_d = ALARME;
        end else if (cnt_q == LIM_BLOQUEIO) begin
          state_d = FECHADO;
          tent_d  = '0;
        end
      end
      ALARME: begin
        if (ev && bus.chave && !bus.porta_aberta) begin
          state_d = FECHADO;
          tent_d  = '0;
        end
      end
      default: begin
        state_d = FECHADO;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Indicator registers are loaded from the next state so they line up with state_q.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FECHADO;
      cnt_q    <= '0;
      tent_q   <= '0;
      pedido_q <= 1'b0;
      trava_q  <= 1'b1;
      alarme_q <= 1'b0;
      aviso_q  <= 1'b0;
      bloq_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tent_q   <= tent_d;
      pedido_q <= bus.pedido;
      trava_q  <= !(state_d == DESTRAVADO || state_d == ABERTO);
      alarme_q <= (state_d == ALARME);
      bloq_q   <= (state_d == BLOQUEADO);
      aviso_q  <= (state_d == ABERTO) && ((cnt_d >= LIM_ABERTA) || !bus.relogio);
    end
  end

  assign bus.trava       = trava_q;
  assign bus.alarme      = alarme_q;
  assign bus.aviso_porta = aviso_q;
  assign bus.bloqueado   = bloq_q;
  assign bus.estado      = state_q;

endmodule
